// File: rtl/hh_spike_monitor.sv
// Windowed spike statistics for the Hodgkin-Huxley core: edge count, last ISI and peak state, reported over valid/ready.
// Optional MON_ISI_MIN_EN adds rpt_isi_min, the smallest ISI completed inside each window.
module hh_spike_monitor #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 8,
  parameter int ISI_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [7:0]       state_in,
  input  logic             rpt_ready,
  output logic             spike_pulse,
  output logic             busy,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic [ISI_W-1:0] rpt_isi,
  output logic [7:0]       rpt_peak,
`ifdef MON_ISI_MIN_EN
  output logic [ISI_W-1:0] rpt_isi_min,
`endif
  output logic             rpt_overrun
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic             spike_q_reg;
  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0] spk_cnt_reg, spk_cnt_next;
  logic [7:0]       peak_reg, peak_next;
  logic [ISI_W-1:0] isi_run_reg, isi_run_next;
  logic             seen_first_reg, seen_first_next;
  logic [ISI_W-1:0] last_isi_reg, last_isi_next;
  logic             rpt_valid_next, rpt_overrun_next;
  logic [CNT_W-1:0] rpt_count_next;
  logic [ISI_W-1:0] rpt_isi_next;
  logic [7:0]       rpt_peak_next;

  logic             edge_evt, run_active, win_end, transfer, load;
  logic [CNT_W-1:0] spk_cnt_upd;
  logic [7:0]       peak_upd;
  logic [ISI_W-1:0] isi_inc, last_isi_upd;

`ifdef MON_ISI_MIN_EN
  logic [ISI_W-1:0] isi_min_reg, isi_min_next, isi_min_upd;
  logic [ISI_W-1:0] rpt_isi_min_next;
`endif

  assign busy = (state_reg == RUN);

  // Window-end snapshot uses the "_upd" values so the final cycle's edge and sample are included.
  always_comb begin
    edge_evt     = spike_in & ~spike_q_reg;
    run_active   = (state_reg == RUN) && en;
    win_end      = run_active && (win_cnt_reg == WIN_LAST);
    transfer     = rpt_valid & rpt_ready;
    load         = win_end && (!rpt_valid || rpt_ready);
    spk_cnt_upd  = (edge_evt && (spk_cnt_reg != CNT_MAX)) ? spk_cnt_reg + 1'b1 : spk_cnt_reg;
    peak_upd     = (state_in > peak_reg) ? state_in : peak_reg;
    isi_inc      = (isi_run_reg == ISI_MAX) ? isi_run_reg : isi_run_reg + 1'b1;
    last_isi_upd = (edge_evt && seen_first_reg) ? isi_inc : last_isi_reg;
`ifdef MON_ISI_MIN_EN
    isi_min_upd  = (edge_evt && seen_first_reg && (isi_inc < isi_min_reg)) ? isi_inc : isi_min_reg;
`endif

    state_next      = state_reg;
    win_cnt_next    = win_cnt_reg;
    spk_cnt_next    = spk_cnt_reg;
    peak_next       = peak_reg;
    isi_run_next    = isi_run_reg;
    seen_first_next = seen_first_reg;
    last_isi_next   = last_isi_reg;
`ifdef MON_ISI_MIN_EN
    isi_min_next    = isi_min_reg;
`endif

    case (state_reg)
      IDLE: begin
        win_cnt_next    = '0;
        spk_cnt_next    = '0;
        peak_next       = '0;
        isi_run_next    = '0;
        seen_first_next = 1'b0;
        last_isi_next   = '0;
`ifdef MON_ISI_MIN_EN
        isi_min_next    = ISI_MAX;
`endif
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) begin
          // Partial window is dropped; IDLE clears the accumulators next cycle.
          state_next = IDLE;
        end else begin
          win_cnt_next    = win_end ? '0 : win_cnt_reg + 1'b1;
          spk_cnt_next    = win_end ? '0 : spk_cnt_upd;
          peak_next       = win_end ? '0 : peak_upd;
          isi_run_next    = edge_evt ? '0 : isi_inc;
          seen_first_next = seen_first_reg | edge_evt;
          last_isi_next   = last_isi_upd;
`ifdef MON_ISI_MIN_EN
          isi_min_next    = win_end ? ISI_MAX : isi_min_upd;
`endif
        end
      end
      default: state_next = IDLE;
    endcase

    rpt_valid_next   = transfer ? 1'b0 : rpt_valid;
    rpt_overrun_next = transfer ? 1'b0 : rpt_overrun;
    rpt_count_next   = rpt_count;
    rpt_isi_next     = rpt_isi;
    rpt_peak_next    = rpt_peak;
`ifdef MON_ISI_MIN_EN
    rpt_isi_min_next = rpt_isi_min;
`endif
    if (load) begin
      rpt_valid_next   = 1'b1;
      rpt_count_next   = spk_cnt_upd;
      rpt_isi_next     = last_isi_upd;
      rpt_peak_next    = peak_upd;
`ifdef MON_ISI_MIN_EN
      rpt_isi_min_next = isi_min_upd;
`endif
    end else if (win_end) begin
      rpt_overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      spike_q_reg    <= 1'b0;
      spike_pulse    <= 1'b0;
      win_cnt_reg    <= '0;
      spk_cnt_reg    <= '0;
      peak_reg       <= '0;
      isi_run_reg    <= '0;
      seen_first_reg <= 1'b0;
      last_isi_reg   <= '0;
      rpt_valid      <= 1'b0;
      rpt_overrun    <= 1'b0;
      rpt_count      <= '0;
      rpt_isi        <= '0;
      rpt_peak       <= '0;
`ifdef MON_ISI_MIN_EN
      isi_min_reg    <= '0;
      rpt_isi_min    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      spike_q_reg    <= spike_in;
      spike_pulse    <= edge_evt;
      win_cnt_reg    <= win_cnt_next;
      spk_cnt_reg    <= spk_cnt_next;
      peak_reg       <= peak_next;
      isi_run_reg    <= isi_run_next;
      seen_first_reg <= seen_first_next;
      last_isi_reg   <= last_isi_next;
      rpt_valid      <= rpt_valid_next;
      rpt_overrun    <= rpt_overrun_next;
      rpt_count      <= rpt_count_next;
      rpt_isi        <= rpt_isi_next;
      rpt_peak       <= rpt_peak_next;
`ifdef MON_ISI_MIN_EN
      isi_min_reg    <= isi_min_next;
      rpt_isi_min    <= rpt_isi_min_next;
`endif
    end
  end

endmodule
